sgd_update_engine: RTL and testbench
====================================

// Module: sgd_update_engine
// PURPOSE
//  Parametrised fixed-point SGD parameter-update engine: for i in [0,count) computes
//  W[i] <= W[i] - lr*G[i] over weight/gradient regions in accelerator memory.
//  Sits beside the FPU datapath; the worker controller starts it with go/done once a
//  backward pass has written gradients. Signed two's-complement Q(DATA_W-FRAC_W).FRAC_W.
// PARAMETERS
//  DATA_W   32  width of weights, gradients, lr (signed fixed-point)
//  FRAC_W   16  fractional bits of every fixed-point operand
//  ADDR_W   32  word address width of memory port
//  CNT_W    16  width of element count / index counter
// PORTS
//  clk        in   1       clock
//  rst_l      in   1       reset, asynchronous, active-low
//  go         in   1       start level; sampled only in IDLE
//  w_base     in   ADDR_W  word address of W[0]; sampled on start
//  g_base     in   ADDR_W  word address of G[0]; sampled on start
//  count      in   CNT_W   elements to update; sampled on start
//  lr         in   DATA_W  learning rate (fixed-point); sampled on start
//  clip_val   in   DATA_W  positive gradient clip bound (GRAD_CLIP_EN only)
//  busy       out  1       high in any state except IDLE/DONE
//  done       out  1       high in DONE
//  sat_seen   out  1       sticky: any result saturated this run
//  mem_req    out  1       memory request valid
//  mem_we     out  1       1 = write, 0 = read
//  mem_addr   out  ADDR_W  word address
//  mem_wdata  out  DATA_W  write data
//  mem_ack    in   1       transaction complete this cycle (read data valid)
//  mem_rdata  in   DATA_W  read data, valid when mem_ack
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, sat_seen, mem_req, mem_we=0; mem_addr, mem_wdata,
//    idx, latched operands=0. Reset mid-run aborts immediately; no write completes.
//  - FSM: IDLE -go-> (count==0 ? DONE : RD_W); RD_W -ack-> RD_G; RD_G -ack-> CALC;
//    CALC -> WR (1 cycle); WR -ack-> (idx==count-1 ? DONE : RD_W, idx++);
//    DONE -!go-> IDLE. go changes while busy are ignored.
//  - Start latches w_base,g_base,count,lr, clears idx and sat_seen.
//  - mem_req=1 in RD_W/RD_G/WR, held with stable addr/we/wdata until mem_ack;
//    one transaction per cycle with mem_req&&mem_ack; mem_ack outside those ignored.
//  - Addr: RD_W/WR -> w_base+idx, RD_G -> g_base+idx (ADDR_W wrap, no check).
//  - RD_W ack latches w; RD_G ack latches g. mem_ack may arrive the cycle req rises.
//  - CALC: p = lr*g full 2*DATA_W signed; p >>>= FRAC_W (arith shift, truncate to -inf);
//    r = w - p at DATA_W+1+DATA_W bits; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1],
//    set sat_seen when clamped; register r as mem_wdata.
//  - Min latency per element 4 cycles (zero-wait ack); total = 4*count+1 cycles to done.
//  - count==max (2^CNT_W-1) fully supported; idx never overflows.
// CONFIGURATION
//  SGD_GRAD_CLIP_EN defined: in CALC, g clamped to [-clip_val, +clip_val] before the
//   multiply; clip_val treated as non-negative. Not defined: clip_val port
//   still present but unused; g used unmodified. No other behaviour differs.
// STRUCTURE
//  Package sgd_update_pkg: state enum {IDLE,RD_W,RD_G,CALC,WR,DONE}, fxp_t typedef
//  (logic signed [DATA_W-1:0]), FXP_MAX/FXP_MIN constants, sat() function.
//  Sub-module sgd_fxp_mac: combinational w - (lr*clip(g))>>>FRAC_W with saturation
//  and sat flag; top holds FSM, counters, operand latches, memory port.
// TESTING (DATA_W=32, FRAC_W=16; zero-wait and random-wait memory model)
//  - w=0x0001_0000, g=0x0000_4000, lr=0x0000_8000, count=1 -> W[0]=0x0000_E000, done, sat_seen=0
//  - count=0, go=1 -> done asserted 1 cycle later, no mem_req ever raised
//  - w=0x8000_0001, g=0x0002_0000, lr=0x0001_0000 -> W=0x8000_0000, sat_seen=1
//  - count=8, random 0-5 cycle ack delays -> all 8 W correct, addresses in order, 33+delay cycles
//  - rst_l low during WR of element 3 of 8 -> all outputs 0 next edge, W[3..7] untouched
//  - SGD_GRAD_CLIP_EN, clip=0x0001_0000, g=0x0005_0000, lr=0x0001_0000, w=0 -> W=0xFFFF_0000

Source files
------------

// File: rtl/sgd_update_pkg.sv
// Shared types and constants for the SGD parameter-update engine.
// Optional gradient clipping is enabled by defining SGD_GRAD_CLIP_EN.
package sgd_update_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  typedef logic signed [DATA_W-1:0] fxp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_W,
    RD_G,
    CALC,
    WR,
    DONE
  } state_t;

  localparam fxp_t FXP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef logic signed [2*DATA_W:0] wide_t;

  localparam wide_t WIDE_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam wide_t WIDE_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic fxp_t sat(input wide_t v);
    if (v > WIDE_MAX) return FXP_MAX;
    if (v < WIDE_MIN) return FXP_MIN;
    return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sgd_update_engine_mac.sv
// Combinational update w - (lr*g)>>>FRAC_W with saturation.
// Gradient clipping to +/-clip_val is compiled in with SGD_GRAD_CLIP_EN.
module sgd_fxp_mac
  import sgd_update_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] lr,
  input  logic [DATA_W-1:0] clip_val,
  output logic [DATA_W-1:0] r,
  output logic              sat
);

  localparam int PW = 2*DATA_W;
  localparam int RW = 2*DATA_W+1;

  localparam logic signed [RW-1:0] R_MAX =
    {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN =
    {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] gc;
  logic signed [PW-1:0]     p;
  logic signed [PW-1:0]     ps;
  logic signed [RW-1:0]     rf;

`ifdef SGD_GRAD_CLIP_EN
  // One extra bit keeps clip_val non-negative and -clip_val representable
  logic signed [DATA_W:0] g_x;
  logic signed [DATA_W:0] c_x;
  logic signed [DATA_W:0] c_n;

  always_comb begin
    g_x = {g[DATA_W-1], g};
    c_x = {1'b0, clip_val};
    c_n = -c_x;
    gc  = g;
    if (g_x > c_x) begin
      gc = clip_val;
    end else if (g_x < c_n) begin
      gc = c_n[DATA_W-1:0];
    end
  end
`else
  logic unused_clip;

  assign unused_clip = ^clip_val;
  assign gc = g;
`endif

  always_comb begin
    p   = $signed(lr) * gc;
    ps  = p >>> FRAC_W;
    rf  = {{(RW-DATA_W){w[DATA_W-1]}}, w}
        - {ps[PW-1], ps};
    r   = rf[DATA_W-1:0];
    sat = 1'b0;
    if (rf > R_MAX) begin
      r   = {1'b0, {(DATA_W-1){1'b1}}};
      sat = 1'b1;
    end else if (rf < R_MIN) begin
      r   = {1'b1, {(DATA_W-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/sgd_update_engine.sv
// SGD update engine: W[i] <= W[i] - lr*G[i] over memory regions.
// Gradient clipping is enabled by defining SGD_GRAD_CLIP_EN.
module sgd_update_engine
  import sgd_update_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] g_base,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] lr,
  input  logic [DATA_W-1:0] clip_val,
  output logic              busy,
  output logic              done,
  output logic              sat_seen,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] w_base_q;
  logic [ADDR_W-1:0] g_base_q;
  logic [DATA_W-1:0] lr_q;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] r;
  logic              sat;
  logic              last;

  // idx stops at cnt-1, so it never wraps even for the largest count
  assign last = (idx == cnt - CNT_W'(1));

  sgd_fxp_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .w        (w_q),
    .g        (g_q),
    .lr       (lr_q),
    .clip_val (clip_val),
    .r        (r),
    .sat      (sat)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nx = (count == '0) ? DONE : RD_W;
        end
      end
      RD_W: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_nx = RD_G;
      end
      RD_G: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_nx = CALC;
      end
      CALC: begin
        busy     = 1'b1;
        state_nx = WR;
      end
      WR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nx = last ? DONE : RD_W;
      end
      DONE: begin
        done = 1'b1;
        if (!go) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      (state == RD_G):
        mem_addr = g_base_q + ADDR_W'(idx);
      (state == RD_W) || (state == WR):
        mem_addr = w_base_q + ADDR_W'(idx);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      idx       <= '0;
      cnt       <= '0;
      w_base_q  <= '0;
      g_base_q  <= '0;
      lr_q      <= '0;
      w_q       <= '0;
      g_q       <= '0;
      mem_wdata <= '0;
      sat_seen  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            w_base_q <= w_base;
            g_base_q <= g_base;
            cnt      <= count;
            lr_q     <= lr;
            idx      <= '0;
            sat_seen <= 1'b0;
          end
        end
        RD_W: if (mem_ack) w_q <= mem_rdata;
        RD_G: if (mem_ack) g_q <= mem_rdata;
        CALC: begin
          mem_wdata <= r;
          if (sat) sat_seen <= 1'b1;
        end
        WR: begin
          if (mem_ack && !last) idx <= idx + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sgd_update_engine.sv
// Self-checking bench for sgd_update_engine against a plain-arithmetic model.
// Exercises the clip path when SGD_GRAD_CLIP_EN is defined.
module tb_sgd_update_engine;

  localparam logic [31:0] WB = 32'h10;
  localparam logic [31:0] GB = 32'h80;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        go = 1'b0;
  logic [31:0] w_base = '0;
  logic [31:0] g_base = '0;
  logic [15:0] count = '0;
  logic [31:0] lr = '0;
  logic [31:0] clip_val = '0;
  logic        busy;
  logic        done;
  logic        sat_seen;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;
  int          max_dly = 0;
  bit          stall = 0;
  int          wait_cnt = 0;
  int          stall_cyc = 0;
  bit          req_seen = 0;
  bit          pending = 0;
  logic [32:0] prev_aw;
  logic [31:0] prev_wd;
  logic [31:0] log_addr[$];
  bit          log_we[$];

  sgd_update_engine u_dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .go        (go),
    .w_base    (w_base),
    .g_base    (g_base),
    .count     (count),
    .lr        (lr),
    .clip_val  (clip_val),
    .busy      (busy),
    .done      (done),
    .sat_seen  (sat_seen),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && !stall && (wait_cnt == 0);
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder with optional random wait states
  always @(posedge clk) begin
    if (mem_req) req_seen = 1;
    if (mem_req && pending) begin
      chk("hold_addr_we", {31'b0, mem_we, mem_addr}, {31'b0, prev_aw});
      chk("hold_wdata", {32'b0, mem_wdata}, {32'b0, prev_wd});
    end
    if (mem_req && mem_ack) begin
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_we);
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      wait_cnt <= (max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0;
      pending = 0;
    end else if (mem_req) begin
      stall_cyc++;
      pending = 1;
      prev_aw = {mem_we, mem_addr};
      prev_wd = mem_wdata;
      if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
    end else begin
      pending = 0;
    end
  end

  function automatic logic [31:0] model(input logic [31:0] w, g, l, c,
                                        output bit s);
    longint gg, cc, p, r;
    gg = longint'($signed(g));
`ifdef SGD_GRAD_CLIP_EN
    cc = longint'(c);
    if (gg > cc) gg = cc;
    if (gg < -cc) gg = -cc;
`else
    cc = longint'(c);
    cc = cc + 0;
`endif
    p = longint'($signed(l)) * gg;
    p = p >>> 16;
    r = longint'($signed(w)) - p;
    s = 0;
    if (r > 64'sd2147483647) begin
      r = 64'sd2147483647;
      s = 1;
    end
    if (r < -64'sd2147483648) begin
      r = -64'sd2147483648;
      s = 1;
    end
    return r[31:0];
  endfunction

  task automatic run(input logic [15:0] n, input logic [31:0] l, c,
                     output int cyc);
    @(negedge clk);
    w_base    = WB;
    g_base    = GB;
    count     = n;
    lr        = l;
    clip_val  = c;
    stall_cyc = 0;
    req_seen  = 0;
    log_addr.delete();
    log_we.delete();
    go  = 1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", {63'b0, done}, 64'd1);
    go = 0;
    @(negedge clk);
  endtask

  task automatic chk_order(input int n);
    int ok = 0;
    for (int i = 0; i < n; i++) begin
      if (log_addr.size() >= 3*i+3) begin
        if (log_addr[3*i] == WB + i && !log_we[3*i]) ok++;
        if (log_addr[3*i+1] == GB + i && !log_we[3*i+1]) ok++;
        if (log_addr[3*i+2] == WB + i && log_we[3*i+2]) ok++;
      end
    end
    chk("addr_order", 64'(ok), 64'(3*n));
    chk("xfer_count", 64'(log_addr.size()), 64'(3*n));
  endtask

  task automatic rand_run(input int dly);
    logic [31:0] wv [8];
    logic [31:0] gv [8];
    logic [31:0] ev [8];
    logic [31:0] l, c;
    bit          s, es;
    int          cyc;
    es = 0;
    l  = $urandom_range(0, 32'h0003_0000);
    c  = $urandom_range(0, 32'h0004_0000);
    for (int i = 0; i < 8; i++) begin
      wv[i] = $urandom;
      gv[i] = 32'($signed($urandom) >>> $urandom_range(0, 15));
      mem[WB+i] <= wv[i];
      mem[GB+i] <= gv[i];
      ev[i] = model(wv[i], gv[i], l, c, s);
      es |= s;
    end
    max_dly = dly;
    run(16'd8, l, c, cyc);
    chk("rand_cycles", 64'(cyc), 64'(33 + stall_cyc));
    chk("rand_sat_seen", {63'b0, sat_seen}, {63'b0, es});
    chk_order(8);
    for (int i = 0; i < 8; i++) begin
      chk("rand_w", {32'b0, mem[WB+i]}, {32'b0, ev[i]});
    end
    max_dly = 0;
  endtask

  initial begin
    int          cyc;
    bit          s;
    bit          found;
    logic [31:0] wv [8];
    logic [31:0] ev [8];
    logic [31:0] exp_w;

    for (int i = 0; i < 256; i++) mem[i] <= $urandom;
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_sat", {63'b0, sat_seen}, 64'd0);
    chk("rst_req_we", {62'b0, mem_req, mem_we}, 64'd0);
    chk("rst_addr", {32'b0, mem_addr}, 64'd0);
    chk("rst_wdata", {32'b0, mem_wdata}, 64'd0);
    @(negedge clk);
    rst_l = 1;

    // 1.0 - 0.5*0.25 = 0.875
    mem[WB] <= 32'h0001_0000;
    mem[GB] <= 32'h0000_4000;
    run(16'd1, 32'h0000_8000, 32'h7fff_ffff, cyc);
    chk("basic_w", {32'b0, mem[WB]}, 64'h0000_E000);
    chk("basic_sat", {63'b0, sat_seen}, 64'd0);
    chk("basic_cycles", 64'(cyc), 64'd5);
    chk_order(1);

    run(16'd0, 32'h0001_0000, 32'h0, cyc);
    chk("zero_cycles", 64'(cyc), 64'd1);
    chk("zero_no_req", {63'b0, req_seen}, 64'd0);

    mem[WB] <= 32'h8000_0001;
    mem[GB] <= 32'h0002_0000;
    run(16'd1, 32'h0001_0000, 32'h7fff_ffff, cyc);
    chk("sat_w", {32'b0, mem[WB]}, 64'h8000_0000);
    chk("sat_seen", {63'b0, sat_seen}, 64'd1);

    mem[WB] <= 32'h0;
    mem[GB] <= 32'h0005_0000;
    run(16'd1, 32'h0001_0000, 32'h0001_0000, cyc);
`ifdef SGD_GRAD_CLIP_EN
    exp_w = 32'hFFFF_0000;
`else
    exp_w = 32'hFFFB_0000;
`endif
    chk("clip_w", {32'b0, mem[WB]}, {32'b0, exp_w});
    chk("clip_sat_cleared", {63'b0, sat_seen}, 64'd0);

    rand_run(0);
    rand_run(5);
    rand_run(5);

    // Reset while the write of element 3 is pending
    for (int i = 0; i < 8; i++) begin
      wv[i] = $urandom;
      mem[WB+i] <= wv[i];
      mem[GB+i] <= $urandom_range(0, 32'h0001_0000);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) ev[i] = model(wv[i], mem[GB+i],
                                             32'h0000_4000, 32'h7fff_ffff, s);
    w_base   = WB;
    g_base   = GB;
    count    = 16'd8;
    lr       = 32'h0000_4000;
    clip_val = 32'h7fff_ffff;
    go       = 1;
    found    = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_addr == WB + 3) found = 1;
    end
    chk("rst_wr3_found", {63'b0, found}, 64'd1);
    stall = 1;
    rst_l = 0;
    go    = 0;
    @(posedge clk);
    #1;
    chk("abort_busy_done", {62'b0, busy, done}, 64'd0);
    chk("abort_req_we", {62'b0, mem_req, mem_we}, 64'd0);
    chk("abort_addr", {32'b0, mem_addr}, 64'd0);
    chk("abort_wdata_sat", {31'b0, sat_seen, mem_wdata}, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("abort_done_w", {32'b0, mem[WB+i]}, {32'b0, ev[i]});
    end
    for (int i = 3; i < 8; i++) begin
      chk("abort_untouched", {32'b0, mem[WB+i]}, {32'b0, wv[i]});
    end
    stall = 0;
    rst_l = 1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
